mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL: clk  in  1  sole clock; every state element updates on posedge clk.
REQ-002 SHALL: reset  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 SHALL: valid_in  in  1  EX/MEM stage holds a live instruction.
REQ-004 SHALL: mem_read_in, mem_write_in, indirect_in, byte_op_in  in  1 each  decoded memory-op bits for the instruction in EX/MEM.
REQ-005 SHALL: addr_in  in  lc3b_word  effective address; wdata_in  in  lc3b_word  store data.
REQ-006 SHALL: d_read, d_write  out  1  data-memory strobes; d_addr  out  lc3b_word; d_wdata  out  lc3b_word; d_byte_en  out  2  byte lanes.
REQ-007 SHALL: d_resp  in  1  one-cycle completion pulse; d_rdata  in  lc3b_word  read data valid with d_resp.
REQ-008 SHALL: mdr_out  out  lc3b_word  formatted load data toward MEM/WB; indirect_out  out  1  completed op was indirect.
REQ-009 SHALL: load_mem_wb  out  1  MEM/WB load enable; stall  out  1  freezes IF..EX/MEM.
REQ-010 SHALL: stall_cycles  out  16  count of stalled cycles (see Configuration).

Function
REQ-011 SHALL: FSM states IDLE, IND_RD, ACC; reset state IDLE.
REQ-012 SHALL: IDLE, valid_in=0 or no mem bit set -> load_mem_wb=1, stall=0, mdr_out=0, no strobes, stay IDLE.
REQ-013 SHALL: IDLE, valid_in=1 and (mem_read_in or mem_write_in) -> stall=1, load_mem_wb=0, no strobes; next IND_RD if indirect_in else ACC.
REQ-014 SHALL: IND_RD drives d_read=1, d_addr={addr_in[15:1],0}, d_byte_en=11; on d_resp capture d_rdata into ptr register and go ACC; else hold.
REQ-015 SHALL: ACC drives d_addr=(indirect_in ? ptr : addr_in), word ops with bit 0 forced 0; d_read=mem_read_in, d_write=mem_write_in (read wins if both set).
REQ-016 SHALL: byte store drives d_wdata={wdata_in[7:0],wdata_in[7:0]}, d_byte_en=10 if addr bit 0 is 1 else 01; word ops d_byte_en=11, d_wdata=wdata_in.
REQ-017 SHALL: byte load sets mdr_out to the selected byte sign-extended to 16 bits; word load passes d_rdata; stores set mdr_out=0.
REQ-018 SHALL: in ACC stall=1 until d_resp; in the d_resp cycle stall=0, load_mem_wb=1, mdr_out combinationally valid, indirect_out=indirect_in, next IDLE.
REQ-019 SHALL: minimum latency is 2 cycles for direct ops and 3 for indirect ops; each extra d_resp wait adds 1.
REQ-020 SHALL: d_resp while in IDLE is ignored.
REQ-021 SHALL: strobes held constant while waiting; never asserted in IDLE.
REQ-022 SHALL: indirect pointer read is always a word access even when byte_op_in=1.

Reset
REQ-023 SHALL: reset -> state IDLE, ptr 0, stall_cycles 0; outputs follow IDLE rules the next cycle.
REQ-024 SHALL: reset during IND_RD/ACC abandons the access; a later d_resp is ignored.

Configuration
REQ-025 SHALL: macro MEM_STALL_CNT_EN defined -> stall_cycles increments every cycle stall=1, saturates at 16'hFFFF, clears on reset.
REQ-026 SHALL: macro undefined -> stall_cycles port kept, tied to 0, no counter logic.

Structure
REQ-027 SHALL: FSM state enum and byte-lane constants belong in lc3b_types beside lc3b_word.
REQ-028 SHALL: load formatting is a combinational sub-module, mem_load_fmt (d_rdata, addr bit 0, byte_op -> mdr).

Verification
REQ-029 SHALL: non-mem op, valid_in=1 -> load_mem_wb=1, stall=0, mdr_out=0 the same cycle.
REQ-030 SHALL: LDR addr 0x3001, d_rdata 0xBEEF after 2 wait cycles -> d_addr 0x3000, mdr_out 0xBEEF, stall high 3 cycles.
REQ-031 SHALL: LDB addr 0x4001, d_rdata 0x80AA -> d_byte_en 10, mdr_out 0xFF80.
REQ-032 SHALL: STB addr 0x4000, wdata 0x1234 -> d_wdata 0x3434, d_byte_en 01, d_write=1.
REQ-033 SHALL: LDI addr 0x5000, pointer 0x6002, data 0x00FF -> second d_addr 0x6002, mdr_out 0x00FF, indirect_out 1.
REQ-034 SHALL: reset in ACC then d_resp -> IDLE, no load_mem_wb pulse; with MEM_STALL_CNT_EN stall_cycles 0.

Source files
------------

// File: rtl/lc3b_types.sv
// lc3b_types: LC-3b word type plus the memory-access FSM states and byte-lane codes
// shared by mem_access_ctrl, its bus interface and the load formatter.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        MA_IDLE   = 2'd0,
        MA_IND_RD = 2'd1,
        MA_ACC    = 2'd2
    } mem_state_e;

    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_WORD = 2'b11;

    // Word accesses always present an even address to memory.
    function automatic lc3b_word word_align(input lc3b_word a);
        return a & 16'hFFFE;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: data-memory bus between the MEM-stage controller (master)
// and the data memory (slave). d_resp is a one-cycle completion pulse.
interface mem_access_ctrl_if;
    import lc3b_types::*;

    logic       d_read;
    logic       d_write;
    lc3b_word   d_addr;
    lc3b_word   d_wdata;
    logic [1:0] d_byte_en;
    logic       d_resp;
    lc3b_word   d_rdata;

    modport master (
        output d_read, d_write, d_addr, d_wdata, d_byte_en,
        input  d_resp, d_rdata
    );

    modport slave (
        input  d_read, d_write, d_addr, d_wdata, d_byte_en,
        output d_resp, d_rdata
    );

endinterface

// File: rtl/mem_load_fmt.sv
// mem_load_fmt: combinational load formatter. Word loads pass through; byte loads
// pick the lane selected by the address LSB and sign-extend it to 16 bits.
module mem_load_fmt
    import lc3b_types::*;
(
    input  lc3b_word d_rdata,
    input  logic     addr_lsb,
    input  logic     byte_op,
    output lc3b_word mdr
);

    logic [7:0] byte_sel;

    // Lane select and sign extension
    always_comb begin
        byte_sel = addr_lsb ? d_rdata[15:8] : d_rdata[7:0];
        mdr      = byte_op ? {{8{byte_sel[7]}}, byte_sel} : d_rdata;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: LC-3b MEM-stage data-memory controller. Handles direct and
// indirect (pointer-then-data) loads/stores, byte lanes and pipeline stall.
// Optional feature: define MEM_STALL_CNT_EN to enable the saturating stall-cycle
// counter on stall_cycles; otherwise stall_cycles is tied to zero.
module mem_access_ctrl
    import lc3b_types::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_in,
    input  logic                mem_read_in,
    input  logic                mem_write_in,
    input  logic                indirect_in,
    input  logic                byte_op_in,
    input  lc3b_word            addr_in,
    input  lc3b_word            wdata_in,
    mem_access_ctrl_if.master   dmem,
    output lc3b_word            mdr_out,
    output logic                indirect_out,
    output logic                load_mem_wb,
    output logic                stall,
    output logic [15:0]         stall_cycles
);

    mem_state_e state_q, state_d;
    lc3b_word   ptr_q, ptr_d;
    logic       mem_op;
    lc3b_word   eff_addr;
    lc3b_word   fmt_data;

    assign mem_op   = mem_read_in | mem_write_in;
    // The second access of an indirect op goes to the fetched pointer.
    assign eff_addr = indirect_in ? ptr_q : addr_in;

    mem_load_fmt u_load_fmt (
        .d_rdata  (dmem.d_rdata),
        .addr_lsb (eff_addr[0]),
        .byte_op  (byte_op_in),
        .mdr      (fmt_data)
    );

    // State and pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MA_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state selection and pointer capture on the indirect read response
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            MA_IDLE: begin
                if (valid_in && mem_op)
                    state_d = indirect_in ? MA_IND_RD : MA_ACC;
            end
            MA_IND_RD: begin
                if (dmem.d_resp) begin
                    ptr_d   = dmem.d_rdata;
                    state_d = MA_ACC;
                end
            end
            MA_ACC: begin
                if (dmem.d_resp)
                    state_d = MA_IDLE;
            end
            default: state_d = MA_IDLE;
        endcase
    end

    // Bus strobes, stall/load handshake and formatted load data per state
    always_comb begin
        dmem.d_read    = 1'b0;
        dmem.d_write   = 1'b0;
        dmem.d_addr    = '0;
        dmem.d_wdata   = '0;
        dmem.d_byte_en = BE_NONE;
        mdr_out        = '0;
        indirect_out   = 1'b0;
        load_mem_wb    = 1'b0;
        stall          = 1'b0;
        case (state_q)
            MA_IDLE: begin
                // A new memory op spends one cycle here before touching the bus.
                if (valid_in && mem_op)
                    stall = 1'b1;
                else
                    load_mem_wb = 1'b1;
            end
            MA_IND_RD: begin
                // Pointer fetch is always a full word, regardless of byte_op_in.
                dmem.d_read    = 1'b1;
                dmem.d_addr    = word_align(addr_in);
                dmem.d_byte_en = BE_WORD;
                stall          = 1'b1;
            end
            MA_ACC: begin
                dmem.d_read  = mem_read_in;
                dmem.d_write = mem_write_in & ~mem_read_in;
                if (byte_op_in) begin
                    dmem.d_addr    = eff_addr;
                    dmem.d_wdata   = {wdata_in[7:0], wdata_in[7:0]};
                    dmem.d_byte_en = eff_addr[0] ? BE_HI : BE_LO;
                end else begin
                    dmem.d_addr    = word_align(eff_addr);
                    dmem.d_wdata   = wdata_in;
                    dmem.d_byte_en = BE_WORD;
                end
                if (dmem.d_resp) begin
                    load_mem_wb  = 1'b1;
                    indirect_out = indirect_in;
                    if (mem_read_in)
                        mdr_out = fmt_data;
                end else begin
                    stall = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef MEM_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of stalled cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed scoreboard bench for mem_access_ctrl. Stimulus
// pushes expected bus accesses and completions; a monitor pops and compares.
module tb_mem_access_ctrl;
    import lc3b_types::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in, mem_read_in, mem_write_in, indirect_in, byte_op_in;
    lc3b_word    addr_in, wdata_in;
    lc3b_word    mdr_out;
    logic        indirect_out, load_mem_wb, stall;
    logic [15:0] stall_cycles;

    mem_access_ctrl_if dmem();

    mem_access_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .mem_read_in  (mem_read_in),
        .mem_write_in (mem_write_in),
        .indirect_in  (indirect_in),
        .byte_op_in   (byte_op_in),
        .addr_in      (addr_in),
        .wdata_in     (wdata_in),
        .dmem         (dmem),
        .mdr_out      (mdr_out),
        .indirect_out (indirect_out),
        .load_mem_wb  (load_mem_wb),
        .stall        (stall),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rd;
        logic       wr;
        lc3b_word   addr;
        lc3b_word   wdata;
        logic [1:0] be;
    } bus_exp_t;

    typedef struct {
        lc3b_word mdr;
        logic     ind;
        int       stalls;
    } cmp_exp_t;

    typedef struct {
        int       waits;
        lc3b_word rdata;
    } rsp_t;

    bus_exp_t bus_q[$];
    cmp_exp_t cmp_q[$];
    rsp_t     rsp_q[$];
    bus_exp_t mb;
    cmp_exp_t mc;
    int       checks = 0;
    int       errors = 0;
    int       rsp_cnt = 0;
    int       stall_run = 0;
    logic     force_resp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_bus(input logic rd, input logic wr, input lc3b_word addr,
                            input lc3b_word wdata, input logic [1:0] be);
        bus_exp_t e;
        e.rd = rd; e.wr = wr; e.addr = addr; e.wdata = wdata; e.be = be;
        bus_q.push_back(e);
    endtask

    task automatic push_cmp(input lc3b_word mdr, input logic ind, input int stalls);
        cmp_exp_t e;
        e.mdr = mdr; e.ind = ind; e.stalls = stalls;
        cmp_q.push_back(e);
    endtask

    task automatic push_rsp(input int waits, input lc3b_word rdata);
        rsp_t e;
        e.waits = waits; e.rdata = rdata;
        rsp_q.push_back(e);
    endtask

    task automatic run_op(input logic rd, input logic wr, input logic ind, input logic byt,
                          input lc3b_word addr, input lc3b_word wdata);
        int n;
        @(posedge clk); #1;
        valid_in = 1'b1; mem_read_in = rd; mem_write_in = wr;
        indirect_in = ind; byte_op_in = byt; addr_in = addr; wdata_in = wdata;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!load_mem_wb && n < 40);
        if (!load_mem_wb) begin
            checks++;
            errors++;
            $display("FAIL op_timeout actual=no_completion required=completion addr=%h", addr);
        end
        @(posedge clk); #1;
        valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        indirect_in = 1'b0; byte_op_in = 1'b0;
    endtask

    // Memory responder: answers each strobed access after its programmed wait count
    initial begin
        dmem.d_resp  = 1'b0;
        dmem.d_rdata = '0;
        forever begin
            @(posedge clk); #2;
            dmem.d_resp = force_resp;
            if ((dmem.d_read || dmem.d_write) && rsp_q.size() > 0) begin
                if (rsp_cnt >= rsp_q[0].waits) begin
                    dmem.d_resp  = 1'b1;
                    dmem.d_rdata = rsp_q[0].rdata;
                    rsp_q.delete(0);
                    rsp_cnt = 0;
                end else begin
                    rsp_cnt++;
                end
            end else begin
                rsp_cnt = 0;
            end
        end
    end

    // Monitor: compares bus accesses and completions against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_run = 0;
            end else begin
                if (dmem.d_resp && (dmem.d_read || dmem.d_write)) begin
                    if (bus_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL bus_unexpected actual=access@%h required=none", dmem.d_addr);
                    end else begin
                        mb = bus_q.pop_front();
                        check("bus_read", dmem.d_read, mb.rd);
                        check("bus_write", dmem.d_write, mb.wr);
                        check("bus_addr", dmem.d_addr, mb.addr);
                        check("bus_byte_en", dmem.d_byte_en, mb.be);
                        if (mb.wr) check("bus_wdata", dmem.d_wdata, mb.wdata);
                    end
                end
                if (valid_in && load_mem_wb) begin
                    if (cmp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL cmp_unexpected actual=completion required=none");
                    end else begin
                        mc = cmp_q.pop_front();
                        check("mdr_out", mdr_out, mc.mdr);
                        check("indirect_out", indirect_out, mc.ind);
                        check("stall_len", stall_run, mc.stalls);
                        check("stall_at_done", stall, 1'b0);
                    end
                    stall_run = 0;
                end else if (stall) begin
                    stall_run++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        reset = 1'b1;
        valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        indirect_in = 1'b0; byte_op_in = 1'b0; addr_in = '0; wdata_in = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_load_mem_wb", load_mem_wb, 1'b1);
        check("rst_stall", stall, 1'b0);
        check("rst_mdr", mdr_out, 16'h0000);
        check("rst_strobes", {dmem.d_read, dmem.d_write}, 2'b00);
        check("rst_stall_cycles", stall_cycles, 16'h0000);

        // Non-memory op completes in the same cycle
        push_cmp(16'h0000, 1'b0, 0);
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000);

        // LDR with two wait cycles
        push_rsp(2, 16'hBEEF);
        push_bus(1'b1, 1'b0, 16'h3000, 16'h0000, BE_WORD);
        push_cmp(16'hBEEF, 1'b0, 3);
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h3001, 16'h0000);

        // LDB high lane, negative
        push_rsp(0, 16'h80AA);
        push_bus(1'b1, 1'b0, 16'h4001, 16'h0000, BE_HI);
        push_cmp(16'hFF80, 1'b0, 1);
        run_op(1'b1, 1'b0, 1'b0, 1'b1, 16'h4001, 16'h0000);

        // LDB low lane, negative and positive
        push_rsp(0, 16'h80AA);
        push_bus(1'b1, 1'b0, 16'h4000, 16'h0000, BE_LO);
        push_cmp(16'hFFAA, 1'b0, 1);
        run_op(1'b1, 1'b0, 1'b0, 1'b1, 16'h4000, 16'h0000);
        push_rsp(0, 16'h7F01);
        push_bus(1'b1, 1'b0, 16'h4002, 16'h0000, BE_LO);
        push_cmp(16'h0001, 1'b0, 1);
        run_op(1'b1, 1'b0, 1'b0, 1'b1, 16'h4002, 16'h0000);

        // STB even and odd lanes
        push_rsp(0, 16'h0000);
        push_bus(1'b0, 1'b1, 16'h4000, 16'h3434, BE_LO);
        push_cmp(16'h0000, 1'b0, 1);
        run_op(1'b0, 1'b1, 1'b0, 1'b1, 16'h4000, 16'h1234);
        push_rsp(0, 16'hFFFF);
        push_bus(1'b0, 1'b1, 16'h4003, 16'hABAB, BE_HI);
        push_cmp(16'h0000, 1'b0, 1);
        run_op(1'b0, 1'b1, 1'b0, 1'b1, 16'h4003, 16'h12AB);

        // d_resp while idle must be ignored
        @(posedge clk); #1 force_resp = 1'b1;
        @(negedge clk);
        check("idle_resp_stall", stall, 1'b0);
        check("idle_resp_strobes", {dmem.d_read, dmem.d_write}, 2'b00);
        check("idle_resp_load", load_mem_wb, 1'b1);
        @(posedge clk); #1 force_resp = 1'b0;

        // STR word, odd address forced even, one wait
        push_rsp(1, 16'h0000);
        push_bus(1'b0, 1'b1, 16'h2000, 16'hCAFE, BE_WORD);
        push_cmp(16'h0000, 1'b0, 2);
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 16'h2001, 16'hCAFE);

        // LDI: pointer then data
        push_rsp(0, 16'h6002);
        push_rsp(0, 16'h00FF);
        push_bus(1'b1, 1'b0, 16'h5000, 16'h0000, BE_WORD);
        push_bus(1'b1, 1'b0, 16'h6002, 16'h0000, BE_WORD);
        push_cmp(16'h00FF, 1'b1, 2);
        run_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h5000, 16'h0000);

        // Indirect byte load: pointer fetch stays a word access
        push_rsp(1, 16'h7003);
        push_rsp(0, 16'h1280);
        push_bus(1'b1, 1'b0, 16'h5000, 16'h0000, BE_WORD);
        push_bus(1'b1, 1'b0, 16'h7003, 16'h0000, BE_HI);
        push_cmp(16'h0012, 1'b1, 3);
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 16'h5001, 16'h0000);

        // STI word
        push_rsp(0, 16'h8001);
        push_rsp(0, 16'h0000);
        push_bus(1'b1, 1'b0, 16'h5002, 16'h0000, BE_WORD);
        push_bus(1'b0, 1'b1, 16'h8000, 16'hABCD, BE_WORD);
        push_cmp(16'h0000, 1'b1, 2);
        run_op(1'b0, 1'b1, 1'b1, 1'b0, 16'h5002, 16'hABCD);

        // Read and write both set: read wins
        push_rsp(0, 16'h5555);
        push_bus(1'b1, 1'b0, 16'h3002, 16'h0000, BE_WORD);
        push_cmp(16'h5555, 1'b0, 1);
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 16'h3002, 16'h9999);

        // Reset while in ACC, then a stray d_resp
        @(posedge clk); #1;
        valid_in = 1'b1; mem_read_in = 1'b1; addr_in = 16'h3100;
        repeat (3) @(negedge clk);
        check("acc_wait_read", dmem.d_read, 1'b1);
        check("acc_wait_stall", stall, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1; valid_in = 1'b0; mem_read_in = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; force_resp = 1'b1;
        @(negedge clk);
        check("post_rst_strobes", {dmem.d_read, dmem.d_write}, 2'b00);
        check("post_rst_stall", stall, 1'b0);
        check("post_rst_mdr", mdr_out, 16'h0000);
        check("post_rst_stall_cycles", stall_cycles, 16'h0000);
        @(posedge clk); #1 force_resp = 1'b0;

        // Normal op after the abandoned access
        push_rsp(0, 16'h1357);
        push_bus(1'b1, 1'b0, 16'h3200, 16'h0000, BE_WORD);
        push_cmp(16'h1357, 1'b0, 1);
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h3200, 16'h0000);

        repeat (4) @(posedge clk);
        check("queues_drained", bus_q.size() + cmp_q.size() + rsp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
